// File: rtl/sha_mem_arb_pkg.sv
// Shared widths, arbiter state type and index helper for the SHA memory-port arbiter.
package sha_mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

  // Index of the set bit in a one-hot vector of up to eight requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sha_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [PTR_W:0] slot;

  // Walk the requesters starting at the pointer; the extra slot bit absorbs the wrap.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    slot   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (slot >= (PTR_W+1)'(NUM_REQ)) slot = slot - (PTR_W+1)'(NUM_REQ);
      if (!valid && req[slot[PTR_W-1:0]]) begin
        winner[slot[PTR_W-1:0]] = 1'b1;
        valid                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin owner arbiter sharing one memory port between NUM_REQ hashing cores.
// Optional forced release after MAX_HOLD cycles is built when SHA_MEM_ARB_TIMEOUT_EN is defined.
module sha_mem_arbiter
  import sha_mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      timeout,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2) begin : g_param_check
    $error("sha_mem_arbiter: NUM_REQ must be 2..8 and MAX_HOLD at least 2");
  end

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] gnt_n, pick_oh;
  logic               pick_valid;
  logic [PTR_W-1:0]   own, own_n, own_inc, rr_ptr, rr_ptr_n, pick_ptr, pick_idx;
  logic               force_rel, release_now;
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = addr[k*ADDR_W +: ADDR_W];
    assign wdata_arr[k] = wdata[k*DATA_W +: DATA_W];
  end

  // While owned, arbitration looks ahead from the slot after the owner so a release hands over on the same edge.
  assign own_inc     = (own == PTR_W'(NUM_REQ - 1)) ? '0 : own + 1'b1;
  assign pick_ptr    = (state == OWNED) ? own_inc : rr_ptr;
  assign pick_idx    = PTR_W'(onehot_to_idx(8'(pick_oh)));
  assign release_now = (state == OWNED) && (!lock[own] || force_rel);

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req   (req),
    .rr_ptr(pick_ptr),
    .winner(pick_oh),
    .valid (pick_valid)
  );

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    own_n    = own;
    rr_ptr_n = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = OWNED;
          gnt_n   = pick_oh;
          own_n   = pick_idx;
        end
      end
      OWNED: begin
        if (release_now) begin
          rr_ptr_n = own_inc;
          if (pick_valid) begin
            gnt_n = pick_oh;
            own_n = pick_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // The read strobe follows the access that produced it, even across a handover edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      own    <= '0;
      rr_ptr <= '0;
      rvalid <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      own    <= own_n;
      rr_ptr <= rr_ptr_n;
      rvalid <= gnt & req & ~we;
    end
  end

  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (state == OWNED) begin
      mem_addr       = addr_arr[own];
      mem_write_data = wdata_arr[own];
      mem_we         = req[own] & we[own];
    end
  end

  assign busy    = (state == OWNED);
  assign rdata   = mem_read_data;
  assign mem_clk = clk;

`ifdef SHA_MEM_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              new_grant;

  assign new_grant = (state_n == OWNED) && ((state == IDLE) || release_now);
  assign force_rel = (state == OWNED) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Counts owned cycles since the latest grant; timeout marks the cycle after a forced release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_rel;
      if (new_grant)
        hold_cnt <= '0;
      else if (state == OWNED)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Self-checking bench for sha_mem_arbiter: vector table plus hand-written burst, reset and timeout sequences.
module tb_sha_mem_arbiter;

  localparam int NUM_REQ = 4;
`ifdef SHA_MEM_ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 8;
`else
  localparam int TB_MAX_HOLD = 256;
`endif

  logic         clk;
  logic         reset;
  logic [3:0]   req, lock, we;
  logic [63:0]  addr;
  logic [127:0] wdata;
  logic [3:0]   gnt, rvalid;
  logic [31:0]  rdata;
  logic         busy, timeout, mem_clk, mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data, mem_read_data;

  sha_mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MAX_HOLD(TB_MAX_HOLD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .lock          (lock),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .busy          (busy),
    .timeout       (timeout),
    .mem_clk       (mem_clk),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with one-cycle read latency
  logic [31:0] mem [0:65535];

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_word(16'(i));
  end

  always @(posedge mem_clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  // Expected memory contents and read-return scoreboard
  logic [31:0] exp_mem [logic [15:0]];

  function automatic logic [31:0] exp_word(input logic [15:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  typedef struct packed {
    logic [3:0]  who;
    logic [31:0] data;
  } rd_t;
  rd_t sbq[$];

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] we;
    logic [3:0] gnt;
    logic       busy;
  } vec_t;
  vec_t tbl [14];

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        exp_timeout;
  logic [15:0] nxt_addr  [4];
  logic [31:0] nxt_wdata [4];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic setAddr(input int k, input logic [15:0] a, input logic [31:0] d);
    nxt_addr[k]  = a;
    nxt_wdata[k] = d;
  endtask

  task automatic setTableAddrs(input int i);
    for (int k = 0; k < 4; k++)
      setAddr(k, 16'h0200 + 16'(k * 16 + i), 32'hD000_0000 | 32'(k << 12) | 32'(i));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic [3:0] w);
    @(negedge clk);
    req  = r;
    lock = l;
    we   = w;
    for (int k = 0; k < 4; k++) begin
      addr[k*16 +: 16]  = nxt_addr[k];
      wdata[k*32 +: 32] = nxt_wdata[k];
    end
  endtask

  // Checks registered state, the memory port for the expected owner, and any due read return.
  task automatic checkOutput(input logic [3:0] exp_gnt, input logic exp_busy, input string tag);
    logic [3:0]  acc, exp_rv;
    logic [15:0] a;
    int          own;
    rd_t         e;
    #1;
    cmp($sformatf("%s.gnt", tag), 32'(gnt), 32'(exp_gnt));
    cmp($sformatf("%s.busy", tag), 32'(busy), 32'(exp_busy));
    cmp($sformatf("%s.timeout", tag), 32'(timeout), 32'(exp_timeout));
    exp_rv = (sbq.size() > 0) ? sbq[0].who : 4'b0000;
    cmp($sformatf("%s.rvalid", tag), 32'(rvalid), 32'(exp_rv));
    if (sbq.size() > 0) begin
      cmp($sformatf("%s.rdata", tag), rdata, sbq[0].data);
      void'(sbq.pop_front());
    end
    acc = exp_gnt & req;
    cmp($sformatf("%s.mem_we", tag), 32'(mem_we), 32'(|(acc & we)));
    if (acc != 4'b0000) begin
      own = 0;
      for (int k = 0; k < 4; k++) if (acc[k]) own = k;
      a = addr[own*16 +: 16];
      cmp($sformatf("%s.mem_addr", tag), 32'(mem_addr), 32'(a));
      if (we[own]) begin
        cmp($sformatf("%s.mem_wdata", tag), mem_write_data, wdata[own*32 +: 32]);
        exp_mem[a] = wdata[own*32 +: 32];
      end else begin
        e.who  = acc;
        e.data = exp_word(a);
        sbq.push_back(e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    exp_timeout = 1'b0;
    for (int k = 0; k < 4; k++) setAddr(k, 16'h0000, 32'h0);

    // Contention rotation (rows 0-7), then read handover (rows 8-13)
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0001, 1'b1};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0010, 1'b1};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0100, 1'b1};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0101, 4'b1000, 1'b1};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b0101, 4'b0001, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    tbl[10] = '{4'b1001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    tbl[11] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b1};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    @(negedge clk);
    #1;
    cmp("reset.gnt", 32'(gnt), 32'h0);
    cmp("reset.rvalid", 32'(rvalid), 32'h0);
    cmp("reset.busy", 32'(busy), 32'h0);
    cmp("reset.timeout", 32'(timeout), 32'h0);
    cmp("reset.mem_we", 32'(mem_we), 32'h0);
    reset = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      setTableAddrs(i);
      applyStimulus(tbl[i].req, tbl[i].lock, tbl[i].we);
      checkOutput(tbl[i].gnt, tbl[i].busy, $sformatf("vec%0d", i));
    end

`ifndef SHA_MEM_ARB_TIMEOUT_EN
    $display("[TB] single requester locked read of 20 words");
    setAddr(0, 16'h0010, 32'h0);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    checkOutput(4'b0000, 1'b0, "single.arb");
    for (int i = 0; i < 20; i++) begin
      setAddr(0, 16'h0010 + 16'(i), 32'h0);
      applyStimulus(4'b0001, 4'b0001, 4'b0000);
      checkOutput(4'b0001, 1'b1, $sformatf("single.rd%0d", i));
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b0001, 1'b1, "single.tail");
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b0000, 1'b0, "single.idle");

    $display("[TB] locked write burst with a pending requester, then readback");
    setAddr(1, 16'h0100, 32'hB0B0_0000);
    setAddr(2, 16'h0100, 32'h0);
    applyStimulus(4'b0010, 4'b0010, 4'b0010);
    checkOutput(4'b0000, 1'b0, "burst.arb");
    for (int j = 0; j < 16; j++) begin
      setAddr(1, 16'h0100 + 16'(j), 32'hB0B0_0000 | 32'(j));
      applyStimulus(4'b0110, (j == 15) ? 4'b0000 : 4'b0010, 4'b0010);
      checkOutput(4'b0010, 1'b1, $sformatf("burst.wr%0d", j));
    end
    for (int j = 0; j < 16; j++) begin
      setAddr(2, 16'h0100 + 16'(j), 32'h0);
      applyStimulus(4'b0100, (j == 15) ? 4'b0000 : 4'b0100, 4'b0000);
      checkOutput(4'b0100, 1'b1, $sformatf("burst.rd%0d", j));
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b0100, 1'b1, "burst.tail");
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b0000, 1'b0, "burst.idle");
`else
    $display("[TB] forced release after MAX_HOLD owned cycles");
    setAddr(1, 16'h0050, 32'h0);
    setAddr(0, 16'h0040, 32'h0);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    checkOutput(4'b0000, 1'b0, "to.arb");
    for (int i = 0; i < 8; i++) begin
      setAddr(0, 16'h0040 + 16'(i), 32'h0);
      applyStimulus(4'b0011, 4'b0001, 4'b0000);
      checkOutput(4'b0001, 1'b1, $sformatf("to.hold%0d", i));
    end
    exp_timeout = 1'b1;
    applyStimulus(4'b0011, 4'b0011, 4'b0000);
    checkOutput(4'b0010, 1'b1, "to.force");
    exp_timeout = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b0010, 1'b1, "to.after");
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b0000, 1'b0, "to.idle");
`endif

    $display("[TB] reset in the middle of a locked read");
    setAddr(3, 16'h0020, 32'h0);
    applyStimulus(4'b1000, 4'b1000, 4'b0000);
    checkOutput(4'b0000, 1'b0, "rst.arb");
    applyStimulus(4'b1000, 4'b1000, 4'b0000);
    checkOutput(4'b1000, 1'b1, "rst.rd0");
    setAddr(3, 16'h0021, 32'h0);
    applyStimulus(4'b1000, 4'b1000, 4'b0000);
    checkOutput(4'b1000, 1'b1, "rst.rd1");
    #2;
    reset = 1'b1;
    #1;
    cmp("rst.now.gnt", 32'(gnt), 32'h0);
    cmp("rst.now.busy", 32'(busy), 32'h0);
    cmp("rst.now.rvalid", 32'(rvalid), 32'h0);
    cmp("rst.now.mem_we", 32'(mem_we), 32'h0);
    sbq.delete();
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b0000, 1'b0, "rst.hold");
    reset = 1'b0;

    setAddr(1, 16'h0030, 32'h0);
    setAddr(3, 16'h0031, 32'h0);
    applyStimulus(4'b1010, 4'b0000, 4'b0000);
    checkOutput(4'b0000, 1'b0, "post.arb");
    applyStimulus(4'b1010, 4'b0000, 4'b0000);
    checkOutput(4'b0010, 1'b1, "post.first");
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b1000, 1'b1, "post.next");
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput(4'b0000, 1'b0, "post.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_mem_arbiter.md
Name: sha_mem_arbiter

Overview:
Shares the single word-addressed message/output memory port between NUM_REQ hashing cores, such as multiple bitcoin_hash instances working on disjoint nonce ranges. Each core issues reads and writes as it does today. The arbiter grants ownership round-robin, holds the grant across a locked burst (message fetch or result write-back), and routes read data back with a per-requester valid strobe. It sits between the cores and the memory; mem_clk is driven from clk.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_HOLD, 256, max consecutive granted cycles before forced release (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  requester k wants a memory access this cycle
lock  in  NUM_REQ  requester k keeps ownership after the current access
we  in  NUM_REQ  write enable per requester
addr  in  NUM_REQ*16  word address per requester, packed, k at [16k+:16]
wdata  in  NUM_REQ*32  write data per requester, packed
gnt  out  NUM_REQ  one-hot ownership, registered
rvalid  out  NUM_REQ  read data valid for requester k
rdata  out  32  read data, shared by all requesters
busy  out  1  an owner exists (state OWNED)
timeout  out  1  forced-release pulse (tied 0 without the optional feature)
mem_clk  out  1  equals clk
mem_we  out  1  memory write enable
mem_addr  out  16  memory address
mem_write_data  out  32  memory write data
mem_read_data  in  32  memory read data, one-cycle latency

Behaviour:
- Reset (async, any state): state=IDLE, gnt=0, rvalid=0, rr_ptr=0, hold_cnt=0, timeout=0. A pending read strobe is dropped.
- States: IDLE (no owner), OWNED (owner index own).
- Picker: lowest index k ≥ rr_ptr (wrapping modulo NUM_REQ) with req[k]=1.
- IDLE: if any req is set, the next edge sets gnt=onehot(pick), state=OWNED, hold_cnt=0. Requests are not serviced in the cycle they are arbitrated, so first access latency is 1 cycle.
- OWNED, access cycle: req[own]=1 means mem_we=we[own], mem_addr=addr[own], mem_write_data=wdata[own]. These are combinational muxes on registered gnt.
- OWNED, no access: if req[own]=0, mem_we=0 and mem_addr/mem_write_data hold the owner's values.
- mem_we is 0 whenever gnt=0.
- Read return: a read access (req&gnt&!we) by owner k at cycle t gives rvalid[k]=1 at t+1 and rdata=mem_read_data. This holds even if ownership changed at that edge.
- Release: in OWNED, if lock[own]=0 (with or without req), ownership ends at the next edge. The cycle's access, if any, still executes.
- After release: rr_ptr=(own+1) mod NUM_REQ. The picker is then evaluated on the same edge with the updated pointer; a winner is granted with no idle bubble, otherwise state=IDLE and gnt=0.
- Fairness: a requester with a pending request waits at most NUM_REQ-1 ownership periods.
- Requesters must not drive req without gnt expecting service. Unowned requests are ignored, not queued.
- Simultaneous events: release and new requests on the same edge hand over directly. A reset during a write aborts after the current edge; the memory is not rolled back.
- Index arithmetic is modulo NUM_REQ; rr_ptr width is $clog2(NUM_REQ).

Optional Feature:
SHA_MEM_ARB_TIMEOUT_EN
- Defined: hold_cnt increments every OWNED cycle. When hold_cnt reaches MAX_HOLD-1, release is forced at the next edge regardless of lock, and timeout pulses high for exactly one cycle. hold_cnt width is $clog2(MAX_HOLD+1) and it clears on every grant.
- Undefined: no counter is built, lock is honoured indefinitely, and timeout=0.

Decomposition:
- Package sha_mem_arb_pkg: ADDR_W=16, DATA_W=32, state enum {IDLE, OWNED}.
- Sub-module rr_pick: combinational round-robin picker with inputs req and rr_ptr, outputs one-hot winner and a valid flag.

Test Plan:
- Single requester: req0 reads addr 0x0010 locked for 20 words (0x0010..0x0023) → gnt0 one cycle after first req, rvalid0 each following cycle, data matches memory, busy=1 throughout.
- Contention: req0..req3 all held with lock=0 → grants rotate 0,1,2,3,0 one per cycle, no idle cycles, mem_we never high for a non-owner.
- Locked burst: owner 1 writes 16 words to 0x0100 with lock=1 while req2 is pending → gnt stays 1 for all 16 writes, gnt2 on the edge after lock1 falls.
- Read handover: owner 0 does its last read (lock=0) at cycle t, req3 pending → rvalid0 at t+1, gnt3 also at t+1.
- Reset mid-burst: assert reset during a locked read → gnt=0, rvalid=0, state IDLE immediately. After release, the first grant goes to the lowest requesting index (rr_ptr=0).
- With SHA_MEM_ARB_TIMEOUT_EN and MAX_HOLD=8: owner holds lock for 20 cycles → forced release after 8 granted cycles, timeout high for 1 cycle, next requester granted.
